// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: handshake and strobe bundle between the multicycle controller and its datapath
// Ports (master = controller side):
//   run, opcode, mem_ready          -> controller inputs
//   datapath strobes, alu_src_b, alu_op, pc_source -> controller outputs
//   state, instr_done, instr_count, error           -> controller status outputs
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);
    logic             run;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_2_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic             error;
    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, instr_count, error
    );
    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, instr_count, error
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS sequencer with memory stall, retire counter and sticky error trap
// Ports:
//   clk  - rising-edge clock
//   arst - asynchronous active-high reset
//   bus  - multicycle_control_fsm_if.master (run/opcode/mem_ready in; strobes and status out)
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic                   clk,
    input logic                   arst,
    multicycle_control_fsm_if.master bus
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12,
        ERROR     = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_st, timeout, done;

    always_comb begin
        mem_st  = state_q inside {FETCH, MEM_READ, MEM_WRITE};
        // mem_ready in the expiring cycle wins, so the timeout only fires on a low cycle
        timeout = (TIMEOUT > 0) && mem_st && !bus.mem_ready && (wait_q == WW'(TIMEOUT - 1));
        done    = (state_q inside {MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB}) ||
                  (state_q == MEM_WRITE && bus.mem_ready);
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = bus.run ? FETCH : IDLE;
            FETCH:     state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    6'h23, 6'h2B: state_d = MEM_ADDR;
                    6'h00:        state_d = R_EXEC;
                    6'h04:        state_d = BRANCH;
                    6'h02:        state_d = JUMP;
                    6'h08:        state_d = ADDI_EXEC;
                    default:      state_d = ERROR;
                endcase
            end
            MEM_ADDR:  state_d = (bus.opcode == 6'h2B) ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = bus.mem_ready ? MEM_WB : MEM_READ;
            R_EXEC:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB: state_d = state_q;
            default:   state_d = ERROR;
        endcase
        if (done)
            state_d = bus.run ? FETCH : IDLE;
        if (timeout)
            state_d = ERROR;
        // any state change restarts the wait count, which covers every entry into a memory state
        wait_d  = (state_d != state_q) ? '0 :
                  (mem_st && !bus.mem_ready) ? wait_q + 1'b1 : wait_q;
        count_d = done ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_2_reg     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE:    bus.alu_src_b = 2'b11;
            MEM_ADDR, ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write = 1'b1;
                bus.mem_2_reg = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
            end
            JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
            end
            ADDI_WB:   bus.reg_write = 1'b1;
            default:   bus.pc_write = 1'b0;
        endcase
        bus.state       = state_q;
        bus.instr_done  = done;
        bus.instr_count = count_q;
        bus.error       = (state_q == ERROR);
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven and directed checks of the multicycle controller
module tb_multicycle_control_fsm;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic arst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CW)) bus ();
    multicycle_control_fsm #(.TIMEOUT(16), .CNT_W(CW)) dut (.clk(clk), .arst(arst), .bus(bus));

    function automatic logic [15:0] mk(input logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                       input logic [1:0] asb, aop, ps);
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
    endfunction

    localparam logic [15:0] S_NONE  = 16'h0;
    localparam logic [15:0] S_FR    = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
    localparam logic [15:0] S_FW    = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
    localparam logic [15:0] S_DEC   = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
    localparam logic [15:0] S_MADDR = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    localparam logic [15:0] S_MRD   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] S_MWB   = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] S_MWR   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] S_REX   = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
    localparam logic [15:0] S_RWB   = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
    localparam logic [15:0] S_BR    = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
    localparam logic [15:0] S_J     = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
    localparam logic [15:0] S_AEX   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
    localparam logic [15:0] S_AWB   = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);

    typedef struct packed {
        logic          run;
        logic [5:0]    op;
        logic          mr;
        logic [3:0]    st;
        logic [15:0]   sb;
        logic          done;
        logic          err;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] sb_act;
    logic [25:0] obs;
    assign sb_act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.mem_2_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.pc_source};
    assign obs = {bus.state, sb_act, bus.instr_done, bus.error, bus.instr_count};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [25:0] expv(input logic [3:0] st, input logic [15:0] sb,
                                         input logic done, input logic err, input logic [CW-1:0] cnt);
        return {st, sb, done, err, cnt};
    endfunction

    function automatic vec_t v(input logic run, input logic [5:0] op, input logic mr, input logic [3:0] st,
                               input logic [15:0] sb, input logic done, input logic [CW-1:0] cnt);
        vec_t r;
        r.run = run; r.op = op; r.mr = mr; r.st = st; r.sb = sb;
        r.done = done; r.err = (st == 4'd15); r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic run, input logic [5:0] op, input logic mr);
        bus.run = run;
        bus.opcode = op;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        #1 arst = 1'b1;
        #1 arst = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b1;

        vecs.push_back(v(0, 6'h00, 1, 4'd0,  S_NONE,  0, 0));
        vecs.push_back(v(1, 6'h00, 1, 4'd0,  S_NONE,  0, 0));
        vecs.push_back(v(1, 6'h00, 1, 4'd1,  S_FR,    0, 0));
        vecs.push_back(v(1, 6'h00, 1, 4'd2,  S_DEC,   0, 0));
        vecs.push_back(v(1, 6'h00, 1, 4'd7,  S_REX,   0, 0));
        vecs.push_back(v(1, 6'h00, 1, 4'd8,  S_RWB,   1, 0));
        vecs.push_back(v(1, 6'h23, 1, 4'd1,  S_FR,    0, 1));
        vecs.push_back(v(1, 6'h23, 1, 4'd2,  S_DEC,   0, 1));
        vecs.push_back(v(1, 6'h23, 1, 4'd3,  S_MADDR, 0, 1));
        vecs.push_back(v(0, 6'h23, 0, 4'd4,  S_MRD,   0, 1));
        vecs.push_back(v(0, 6'h23, 0, 4'd4,  S_MRD,   0, 1));
        vecs.push_back(v(1, 6'h23, 1, 4'd4,  S_MRD,   0, 1));
        vecs.push_back(v(1, 6'h23, 1, 4'd5,  S_MWB,   1, 1));
        vecs.push_back(v(1, 6'h2B, 1, 4'd1,  S_FR,    0, 2));
        vecs.push_back(v(1, 6'h2B, 1, 4'd2,  S_DEC,   0, 2));
        vecs.push_back(v(1, 6'h2B, 1, 4'd3,  S_MADDR, 0, 2));
        vecs.push_back(v(1, 6'h2B, 1, 4'd6,  S_MWR,   1, 2));
        vecs.push_back(v(1, 6'h04, 1, 4'd1,  S_FR,    0, 3));
        vecs.push_back(v(1, 6'h04, 1, 4'd2,  S_DEC,   0, 3));
        vecs.push_back(v(1, 6'h04, 1, 4'd9,  S_BR,    1, 3));
        vecs.push_back(v(1, 6'h02, 1, 4'd1,  S_FR,    0, 4));
        vecs.push_back(v(1, 6'h02, 1, 4'd2,  S_DEC,   0, 4));
        vecs.push_back(v(1, 6'h02, 1, 4'd10, S_J,     1, 4));
        vecs.push_back(v(1, 6'h08, 1, 4'd1,  S_FR,    0, 5));
        vecs.push_back(v(1, 6'h08, 1, 4'd2,  S_DEC,   0, 5));
        vecs.push_back(v(1, 6'h08, 1, 4'd11, S_AEX,   0, 5));
        vecs.push_back(v(0, 6'h08, 1, 4'd12, S_AWB,   1, 5));
        vecs.push_back(v(0, 6'h08, 1, 4'd0,  S_NONE,  0, 6));
        vecs.push_back(v(1, 6'h3F, 1, 4'd0,  S_NONE,  0, 6));
        vecs.push_back(v(1, 6'h3F, 0, 4'd1,  S_FW,    0, 6));
        vecs.push_back(v(1, 6'h3F, 1, 4'd1,  S_FR,    0, 6));
        vecs.push_back(v(1, 6'h3F, 1, 4'd2,  S_DEC,   0, 6));
        vecs.push_back(v(1, 6'h3F, 1, 4'd15, S_NONE,  0, 6));

        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].op, vecs[i].mr);
            check($sformatf("vec%0d", i), 32'(obs),
                  32'(expv(vecs[i].st, vecs[i].sb, vecs[i].done, vecs[i].err, vecs[i].cnt)));
            @(negedge clk);
        end

        // sticky ERROR regardless of run/mem_ready
        for (int i = 0; i < 20; i++) begin
            drive(i[0], 6'h00, i[1]);
            check("err_hold", 32'(obs), 32'(expv(4'd15, S_NONE, 0, 1, 4'd6)));
            @(negedge clk);
        end
        do_reset();
        check("err_clear", 32'(obs), 32'(expv(4'd0, S_NONE, 0, 0, 4'd0)));

        // timeout: 16 FETCH cycles with mem_ready low
        drive(1, 6'h00, 0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(1, 6'h00, 0);
            check("to_fetch", 32'(bus.state), 32'd1);
            @(negedge clk);
        end
        check("to_error", 32'(obs), 32'(expv(4'd15, S_NONE, 0, 1, 4'd0)));
        do_reset();

        // mem_ready on the 16th cycle wins over the timeout
        drive(1, 6'h00, 0);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            drive(1, 6'h00, 0);
            check("to_wait", 32'(bus.state), 32'd1);
            @(negedge clk);
        end
        drive(1, 6'h00, 1);
        check("to_last", 32'(obs), 32'(expv(4'd1, S_FR, 0, 0, 4'd0)));
        @(negedge clk);
        check("to_rescue", 32'(obs), 32'(expv(4'd2, S_DEC, 0, 0, 4'd0)));
        do_reset();

        // retire a J, then reset in the middle of a stalled SW
        drive(1, 6'h02, 1);
        repeat (4) @(negedge clk);
        drive(1, 6'h2B, 1);
        check("pre_sw", 32'(obs), 32'(expv(4'd1, S_FR, 0, 0, 4'd1)));
        repeat (3) @(negedge clk);
        drive(1, 6'h2B, 0);
        check("in_mwr", 32'(obs), 32'(expv(4'd6, S_MWR, 0, 0, 4'd1)));
        arst = 1'b1;
        #1;
        check("arst_async", 32'(obs), 32'(expv(4'd0, S_NONE, 0, 0, 4'd0)));
        #1 arst = 1'b0;

        // counter wrap: 16 back-to-back jumps
        drive(1, 6'h02, 1);
        repeat (46) @(negedge clk);
        #1;
        check("cnt_15", 32'(obs), 32'(expv(4'd1, S_FR, 0, 0, 4'd15)));
        repeat (3) @(negedge clk);
        #1;
        check("cnt_wrap", 32'(obs), 32'(expv(4'd1, S_FR, 0, 0, 4'd0)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
